// File: rtl/axi_rd_arbiter.sv
// ============================================================================
// Module   : axi_rd_arbiter
// Purpose  : Shares one AXI read slave (AR + R channels) between NM read
//            masters. One master is granted at a time. The grant is held from
//            the address beat until the last read-data beat of that burst, so
//            R-channel routing needs no ID remapping.
//            Compile option AXI_RDARB_FIXED_PRIO_EN selects fixed priority
//            (lowest index wins). Without it, arbitration is round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_rd_arbiter #(
    parameter int NM = 2,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rstn,
    // Master read-address channels (master i at slice [i*W +: W])
    input  logic [NM*4-1:0]   m_arid,
    input  logic [NM*AW-1:0]  m_araddr,
    input  logic [NM*4-1:0]   m_arlen,
    input  logic [NM*3-1:0]   m_arsize,
    input  logic [NM*2-1:0]   m_arburst,
    input  logic [NM*2-1:0]   m_arlock,
    input  logic [NM*4-1:0]   m_arcache,
    input  logic [NM*3-1:0]   m_arprot,
    input  logic [NM-1:0]     m_arvalid,
    output logic [NM-1:0]     m_arready,
    // Master read-data channels (payload shared, valid/ready per master)
    output logic [3:0]        m_rid,
    output logic [DW-1:0]     m_rdata,
    output logic [1:0]        m_rresp,
    output logic              m_rlast,
    output logic [NM-1:0]     m_rvalid,
    input  logic [NM-1:0]     m_rready,
    // Slave read-address channel
    output logic [3:0]        s_arid,
    output logic [AW-1:0]     s_araddr,
    output logic [3:0]        s_arlen,
    output logic [2:0]        s_arsize,
    output logic [1:0]        s_arburst,
    output logic [1:0]        s_arlock,
    output logic [3:0]        s_arcache,
    output logic [2:0]        s_arprot,
    output logic              s_arvalid,
    input  logic              s_arready,
    // Slave read-data channel
    input  logic [3:0]        s_rid,
    input  logic [DW-1:0]     s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rlast,
    input  logic              s_rvalid,
    output logic              s_rready,
    // Status
    output logic [1:0]        gnt,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    winner;
    logic [NM-1:0] gnt_oh;
    logic          ar_hs;
    logic          r_last_hs;

    // One-hot decode of the registered grant, used to steer per-master signals
    always_comb begin
        gnt_oh = '0;
        for (int i = 0; i < NM; i++) begin
            gnt_oh[i] = (gnt_q == 2'(i));
        end
    end

`ifdef AXI_RDARB_FIXED_PRIO_EN
    // Fixed priority: the lowest-index requesting master wins
    always_comb begin
        winner = 2'd0;
        for (int i = NM - 1; i >= 0; i--) begin
            if (m_arvalid[i]) winner = 2'(i);
        end
    end
`else
    logic [1:0] ptr_q, ptr_d;
    logic       found;
    int         idx;

    // Round-robin: search upward from ptr, wrapping modulo NM; first requester wins
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NM; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NM) idx = idx - NM;
            for (int i = 0; i < NM; i++) begin
                if (!found && (i == idx) && m_arvalid[i]) begin
                    winner = 2'(i);
                    found  = 1'b1;
                end
            end
        end
    end

    // Pointer moves to the master after the one whose burst just completed
    always_comb begin
        ptr_d = ptr_q;
        if (r_last_hs) begin
            ptr_d = (gnt_q == 2'(NM - 1)) ? 2'd0 : gnt_q + 2'd1;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ptr_q <= 2'd0;
        else       ptr_q <= ptr_d;
    end
`endif

    // Channel steering: only the granted master sees ready/valid; IDLE drives all zero
    always_comb begin
        m_arready = '0;
        m_rvalid  = '0;
        s_arvalid = 1'b0;
        s_arid    = '0;
        s_araddr  = '0;
        s_arlen   = '0;
        s_arsize  = '0;
        s_arburst = '0;
        s_arlock  = '0;
        s_arcache = '0;
        s_arprot  = '0;
        s_rready  = 1'b0;
        for (int i = 0; i < NM; i++) begin
            if (gnt_oh[i] && (state_q == ADDR)) begin
                s_arvalid    = m_arvalid[i];
                s_arid       = m_arid[i*4 +: 4];
                s_araddr     = m_araddr[i*AW +: AW];
                s_arlen      = m_arlen[i*4 +: 4];
                s_arsize     = m_arsize[i*3 +: 3];
                s_arburst    = m_arburst[i*2 +: 2];
                s_arlock     = m_arlock[i*2 +: 2];
                s_arcache    = m_arcache[i*4 +: 4];
                s_arprot     = m_arprot[i*3 +: 3];
                m_arready[i] = s_arready;
            end
            if (gnt_oh[i] && (state_q == DATA)) begin
                m_rvalid[i] = s_rvalid;
                s_rready    = m_rready[i];
            end
        end
    end

    // R payload is shared; only the per-master valids qualify it
    assign m_rid   = s_rid;
    assign m_rdata = s_rdata;
    assign m_rresp = s_rresp;
    assign m_rlast = s_rlast;

    assign ar_hs     = s_arvalid & s_arready;
    assign r_last_hs = (state_q == DATA) & s_rvalid & s_rready & s_rlast;

    // Next-state logic: grant in IDLE, hold through the AR handshake and the burst
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (|m_arvalid) begin
                    gnt_d   = winner;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (ar_hs) state_d = DATA;
            end
            DATA: begin
                if (r_last_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and grant registers; reset abandons any in-flight burst
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            gnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt  = gnt_q;
    assign busy = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
// ============================================================================
// Module   : tb_axi_rd_arbiter
// Purpose  : Directed self-checking bench for axi_rd_arbiter (NM=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_rd_arbiter;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk;
    logic              rstn;
    logic [NM*4-1:0]   m_arid;
    logic [NM*AW-1:0]  m_araddr;
    logic [NM*4-1:0]   m_arlen;
    logic [NM*3-1:0]   m_arsize;
    logic [NM*2-1:0]   m_arburst;
    logic [NM*2-1:0]   m_arlock;
    logic [NM*4-1:0]   m_arcache;
    logic [NM*3-1:0]   m_arprot;
    logic [NM-1:0]     m_arvalid;
    logic [NM-1:0]     m_arready;
    logic [3:0]        m_rid;
    logic [DW-1:0]     m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast;
    logic [NM-1:0]     m_rvalid;
    logic [NM-1:0]     m_rready;
    logic [3:0]        s_arid;
    logic [AW-1:0]     s_araddr;
    logic [3:0]        s_arlen;
    logic [2:0]        s_arsize;
    logic [1:0]        s_arburst;
    logic [1:0]        s_arlock;
    logic [3:0]        s_arcache;
    logic [2:0]        s_arprot;
    logic              s_arvalid;
    logic              s_arready;
    logic [3:0]        s_rid;
    logic [DW-1:0]     s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rlast;
    logic              s_rvalid;
    logic              s_rready;
    logic [1:0]        gnt;
    logic              busy;

    int n_cmp;
    int n_fail;

    axi_rd_arbiter #(.NM(NM), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rstn(rstn),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .gnt(gnt), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load one master's AR payload
    task automatic set_ar(input int m, input logic [AW-1:0] addr, input logic [3:0] len);
        m_araddr[m*AW +: AW] = addr;
        m_arlen[m*4 +: 4]    = len;
        m_arid[m*4 +: 4]     = 4'(m + 5);
    endtask

    // Present one slave R beat
    task automatic set_r(input logic v, input logic [DW-1:0] d, input logic last);
        s_rvalid = v;
        s_rdata  = d;
        s_rlast  = last;
        s_rid    = 4'h9;
        s_rresp  = 2'b00;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #3;
        n_cmp++; if (gnt !== 2'd0)       begin n_fail++; $display("FAIL reset_gnt: got %0d want 0", gnt); end
        n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (s_arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_s_arvalid: got %b want 0", s_arvalid); end
        n_cmp++; if (s_rready !== 1'b0)  begin n_fail++; $display("FAIL reset_s_rready: got %b want 0", s_rready); end
        n_cmp++; if (m_arready !== 2'b00) begin n_fail++; $display("FAIL reset_m_arready: got %b want 00", m_arready); end
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single_request();
        set_ar(1, 32'h1000, 4'd3);
        m_arvalid = 2'b10;
        s_arready = 1'b1;
        #1;
        n_cmp++; if (s_arvalid !== 1'b0) begin n_fail++; $display("FAIL single_c0_arvalid: got %b want 0", s_arvalid); end
        tick();
        n_cmp++; if (s_arvalid !== 1'b1)      begin n_fail++; $display("FAIL single_c1_arvalid: got %b want 1", s_arvalid); end
        n_cmp++; if (s_araddr !== 32'h1000)   begin n_fail++; $display("FAIL single_araddr: got %h want 00001000", s_araddr); end
        n_cmp++; if (s_arlen !== 4'd3)        begin n_fail++; $display("FAIL single_arlen: got %0d want 3", s_arlen); end
        n_cmp++; if (s_arid !== 4'd6)         begin n_fail++; $display("FAIL single_arid: got %0d want 6", s_arid); end
        n_cmp++; if (gnt !== 2'd1)            begin n_fail++; $display("FAIL single_gnt: got %0d want 1", gnt); end
        n_cmp++; if (m_arready !== 2'b10)     begin n_fail++; $display("FAIL single_arready: got %b want 10", m_arready); end
        tick();
        m_arvalid = 2'b00;
        s_arready = 1'b0;
        m_rready  = 2'b11;
        for (int b = 0; b < 4; b++) begin
            set_r(1'b1, 32'hA000 + 32'(b), (b == 3));
            #1;
            n_cmp++; if (m_rvalid !== 2'b10) begin n_fail++; $display("FAIL single_rvalid_b%0d: got %b want 10", b, m_rvalid); end
            n_cmp++; if (m_rdata !== 32'hA000 + 32'(b)) begin n_fail++; $display("FAIL single_rdata_b%0d: got %h want %h", b, m_rdata, 32'hA000 + 32'(b)); end
            n_cmp++; if (busy !== 1'b1)      begin n_fail++; $display("FAIL single_busy_b%0d: got %b want 1", b, busy); end
            tick();
        end
        set_r(1'b0, 32'h0, 1'b0);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after_last: got %b want 0", busy); end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_g [4];
`ifdef AXI_RDARB_FIXED_PRIO_EN
        exp_g = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
        exp_g = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
        set_ar(0, 32'h100, 4'd0);
        set_ar(1, 32'h200, 4'd0);
        m_arvalid = 2'b11;
        s_arready = 1'b1;
        m_rready  = 2'b11;
        for (int n = 0; n < 4; n++) begin
            tick();
            n_cmp++; if (gnt !== exp_g[n]) begin n_fail++; $display("FAIL fair_gnt_%0d: got %0d want %0d", n, gnt, exp_g[n]); end
            n_cmp++; if (m_arready !== (2'b01 << exp_g[n])) begin n_fail++; $display("FAIL fair_arready_%0d: got %b want %b", n, m_arready, 2'b01 << exp_g[n]); end
            tick();
            set_r(1'b1, 32'hB0 + 32'(n), 1'b1);
            tick();
            set_r(1'b0, 32'h0, 1'b0);
        end
        m_arvalid = 2'b00;
        s_arready = 1'b0;
    endtask

    task automatic test_backpressure();
        set_ar(0, 32'h2000, 4'd1);
        m_arvalid = 2'b01;
        s_arready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (s_arvalid !== 1'b1)    begin n_fail++; $display("FAIL bp_arvalid_c%0d: got %b want 1", c, s_arvalid); end
            n_cmp++; if (s_araddr !== 32'h2000) begin n_fail++; $display("FAIL bp_araddr_c%0d: got %h want 00002000", c, s_araddr); end
            n_cmp++; if (m_arready !== 2'b00)   begin n_fail++; $display("FAIL bp_arready_c%0d: got %b want 00", c, m_arready); end
            tick();
        end
        s_arready = 1'b1;
        #1;
        n_cmp++; if (m_arready !== 2'b01) begin n_fail++; $display("FAIL bp_arready_go: got %b want 01", m_arready); end
        tick();
        m_arvalid = 2'b00;
        s_arready = 1'b0;
        m_rready  = 2'b00;
        set_r(1'b1, 32'hC0, 1'b0);
        #1;
        n_cmp++; if (s_rready !== 1'b0)  begin n_fail++; $display("FAIL bp_rready_held: got %b want 0", s_rready); end
        n_cmp++; if (m_rvalid !== 2'b01) begin n_fail++; $display("FAIL bp_rvalid_held: got %b want 01", m_rvalid); end
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy_held: got %b want 1", busy); end
        m_rready = 2'b01;
        #1;
        n_cmp++; if (s_rready !== 1'b1) begin n_fail++; $display("FAIL bp_rready_go: got %b want 1", s_rready); end
        tick();
        set_r(1'b1, 32'hC1, 1'b1);
        tick();
        set_r(1'b0, 32'h0, 1'b0);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_late_contender();
        set_ar(1, 32'h3000, 4'd1);
        set_ar(0, 32'h4000, 4'd0);
        m_arvalid = 2'b10;
        s_arready = 1'b1;
        m_rready  = 2'b11;
        tick();
        n_cmp++; if (gnt !== 2'd1) begin n_fail++; $display("FAIL late_gnt1: got %0d want 1", gnt); end
        tick();
        s_arready = 1'b0;
        m_arvalid = 2'b01;
        for (int b = 0; b < 2; b++) begin
            set_r(1'b1, 32'hD0 + 32'(b), (b == 1));
            #1;
            n_cmp++; if (m_arready !== 2'b00) begin n_fail++; $display("FAIL late_arready_b%0d: got %b want 00", b, m_arready); end
            n_cmp++; if (m_rvalid !== 2'b10)  begin n_fail++; $display("FAIL late_rvalid_b%0d: got %b want 10", b, m_rvalid); end
            tick();
        end
        set_r(1'b0, 32'h0, 1'b0);
        n_cmp++; if (s_arvalid !== 1'b0) begin n_fail++; $display("FAIL late_idle_arvalid: got %b want 0", s_arvalid); end
        n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL late_idle_busy: got %b want 0", busy); end
        tick();
        n_cmp++; if (gnt !== 2'd0)          begin n_fail++; $display("FAIL late_gnt0: got %0d want 0", gnt); end
        n_cmp++; if (s_arvalid !== 1'b1)    begin n_fail++; $display("FAIL late_arvalid0: got %b want 1", s_arvalid); end
        n_cmp++; if (s_araddr !== 32'h4000) begin n_fail++; $display("FAIL late_araddr0: got %h want 00004000", s_araddr); end
        s_arready = 1'b1;
        tick();
        m_arvalid = 2'b00;
        s_arready = 1'b0;
        set_r(1'b1, 32'hE0, 1'b1);
        tick();
        set_r(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        set_ar(1, 32'h5000, 4'd3);
        m_arvalid = 2'b10;
        s_arready = 1'b1;
        m_rready  = 2'b11;
        tick();
        tick();
        m_arvalid = 2'b00;
        s_arready = 1'b0;
        set_r(1'b1, 32'hF0, 1'b0);
        tick();
        set_r(1'b1, 32'hF1, 1'b0);
        #1;
        n_cmp++; if (m_rvalid !== 2'b10) begin n_fail++; $display("FAIL rst_pre_rvalid: got %b want 10", m_rvalid); end
        rstn = 1'b0;
        #1;
        n_cmp++; if (m_rvalid !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid: got %b want 00", m_rvalid); end
        n_cmp++; if (s_rready !== 1'b0)  begin n_fail++; $display("FAIL rst_rready: got %b want 0", s_rready); end
        n_cmp++; if (gnt !== 2'd0)       begin n_fail++; $display("FAIL rst_gnt: got %0d want 0", gnt); end
        n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        set_r(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        m_arvalid = 2'b10;
        s_arready = 1'b1;
        tick();
        n_cmp++; if (gnt !== 2'd1)       begin n_fail++; $display("FAIL rst_after_gnt: got %0d want 1", gnt); end
        n_cmp++; if (s_arvalid !== 1'b1) begin n_fail++; $display("FAIL rst_after_arvalid: got %b want 1", s_arvalid); end
        tick();
        m_arvalid = 2'b00;
        s_arready = 1'b0;
        set_r(1'b1, 32'h11, 1'b1);
        tick();
        set_r(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_isolation();
        set_ar(0, 32'h6000, 4'd2);
        m_arvalid = 2'b00;
        m_rready  = 2'b11;
        set_r(1'b1, 32'h77, 1'b1);
        #1;
        n_cmp++; if (s_rready !== 1'b0)  begin n_fail++; $display("FAIL iso_rready: got %b want 0", s_rready); end
        n_cmp++; if (m_rvalid !== 2'b00) begin n_fail++; $display("FAIL iso_rvalid: got %b want 00", m_rvalid); end
        n_cmp++; if (s_araddr !== '0)    begin n_fail++; $display("FAIL iso_araddr: got %h want 0", s_araddr); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL iso_busy: got %b want 0", busy); end
        set_r(1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        m_arid    = '0;
        m_araddr  = '0;
        m_arlen   = '0;
        m_arsize  = '0;
        m_arburst = '0;
        m_arlock  = '0;
        m_arcache = '0;
        m_arprot  = '0;
        m_arvalid = '0;
        m_rready  = '0;
        s_arready = 1'b0;
        s_rid     = '0;
        s_rdata   = '0;
        s_rresp   = '0;
        s_rlast   = 1'b0;
        s_rvalid  = 1'b0;
        rstn      = 1'b0;

        test_reset();
        test_single_request();
        test_fairness();
        test_backpressure();
        test_late_contender();
        test_reset_mid_burst();
        test_isolation();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
